adc_scan_avg: RTL and testbench

- Scan controller and averager that sits directly downstream of the MCP0832 serial ADC reader and also drives its control inputs.
- Alternately requests conversions on ADC channel 0 and channel 1 at a fixed sample period.
- Captures each result when the reader's DONE_RD goes high, and accumulates 2^LOG2_N samples per channel.
- Publishes per-channel averages with a one-cycle valid strobe for the oximeter processing logic.

---
 rtl/adc_scan_avg.sv | 179 +++++++++++++++++
 tb/tb_adc_scan_avg.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_avg.sv
// Two-channel ADC scan controller: alternates conversions on ch0/ch1 and
// publishes a per-channel average of 2^LOG2_N captured samples.
module adc_scan_avg #(
  parameter int IN_W    = 13,
  parameter int LOG2_N  = 2,
  parameter int PERIOD  = 1000,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [IN_W-1:0] adc_value,
  input  logic            adc_done,
  output logic            adc_enable,
  output logic            adc_channel,
  output logic [IN_W-1:0] ch0_avg,
  output logic [IN_W-1:0] ch1_avg,
  output logic            avg_valid,
  output logic            avg_channel,
  output logic            timeout_err
);

  localparam int AW = IN_W + LOG2_N;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(PERIOD);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PLAST = PW'(PERIOD - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, GAP} state_t;

  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic              chan_q, chan_d;
  logic [IN_W-1:0]   ch0_q, ch0_d;
  logic [IN_W-1:0]   ch1_q, ch1_d;
  logic              valid_q, valid_d;
  logic              avg_ch_q, avg_ch_d;
  logic              terr_q, terr_d;
  logic [AW-1:0]     acc0_q, acc0_d;
  logic [AW-1:0]     acc1_q, acc1_d;
  logic [LOG2_N-1:0] cnt0_q, cnt0_d;
  logic [LOG2_N-1:0] cnt1_q, cnt1_d;
  logic [PW-1:0]     period_q, period_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [AW-1:0]     sum;

  assign sum = (chan_q ? acc1_q : acc0_q) + AW'(adc_value);

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    chan_d   = chan_q;
    ch0_d    = ch0_q;
    ch1_d    = ch1_q;
    valid_d  = 1'b0;
    avg_ch_d = avg_ch_q;
    terr_d   = terr_q;
    acc0_d   = acc0_q;
    acc1_d   = acc1_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    period_d = period_q;
    timer_d  = timer_q;
    // Stopping abandons any partial average but keeps published results.
    if (state_q != IDLE && !run) begin
      state_d = IDLE;
      en_d    = 1'b0;
      acc0_d  = '0;
      acc1_d  = '0;
      cnt0_d  = '0;
      cnt1_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          en_d = 1'b0;
          if (run) begin
            en_d     = 1'b1;
            chan_d   = 1'b0;
            timer_d  = '0;
            period_d = '0;
            terr_d   = 1'b0;
            state_d  = CONVERT;
          end
        end
        CONVERT: begin
          timer_d  = timer_q + 1'b1;
          period_d = period_q + 1'b1;
          if (adc_done) begin
            en_d    = 1'b0;
            state_d = GAP;
            if (!chan_q) begin
              if (cnt0_q == '1) begin
                ch0_d    = sum[AW-1:LOG2_N];
                valid_d  = 1'b1;
                avg_ch_d = 1'b0;
                acc0_d   = '0;
                cnt0_d   = '0;
              end else begin
                acc0_d = sum;
                cnt0_d = cnt0_q + 1'b1;
              end
            end else begin
              if (cnt1_q == '1) begin
                ch1_d    = sum[AW-1:LOG2_N];
                valid_d  = 1'b1;
                avg_ch_d = 1'b1;
                acc1_d   = '0;
                cnt1_d   = '0;
              end else begin
                acc1_d = sum;
                cnt1_d = cnt1_q + 1'b1;
              end
            end
          end else if (timer_q == TLAST) begin
            en_d    = 1'b0;
            terr_d  = 1'b1;
            state_d = GAP;
          end
        end
        GAP: begin
          en_d = 1'b0;
          if (period_q != PLAST) begin
            period_d = period_q + 1'b1;
          end else if (!adc_done) begin
            en_d     = 1'b1;
            chan_d   = ~chan_q;
            timer_d  = '0;
            period_d = '0;
            state_d  = CONVERT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      chan_q   <= 1'b0;
      ch0_q    <= '0;
      ch1_q    <= '0;
      valid_q  <= 1'b0;
      avg_ch_q <= 1'b0;
      terr_q   <= 1'b0;
      acc0_q   <= '0;
      acc1_q   <= '0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      period_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      chan_q   <= chan_d;
      ch0_q    <= ch0_d;
      ch1_q    <= ch1_d;
      valid_q  <= valid_d;
      avg_ch_q <= avg_ch_d;
      terr_q   <= terr_d;
      acc0_q   <= acc0_d;
      acc1_q   <= acc1_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      period_q <= period_d;
      timer_q  <= timer_d;
    end
  end

  assign adc_enable  = en_q;
  assign adc_channel = chan_q;
  assign ch0_avg     = ch0_q;
  assign ch1_avg     = ch1_q;
  assign avg_valid   = valid_q;
  assign avg_channel = avg_ch_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_adc_scan_avg.sv
// Directed bench for adc_scan_avg with a behavioural MCP0832 reader model
// that raises done 20 cycles after enable rises and holds it until enable falls.
module tb_adc_scan_avg;

  localparam int IN_W = 13;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            run = 1'b0;
  logic [IN_W-1:0] adc_value;
  logic            adc_done;
  logic            adc_enable;
  logic            adc_channel;
  logic [IN_W-1:0] ch0_avg;
  logic [IN_W-1:0] ch1_avg;
  logic            avg_valid;
  logic            avg_channel;
  logic            timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic withhold = 1'b0;
  logic stuck = 1'b0;
  int   def0 = 0;
  int   def1 = 5;
  int   q0[$];
  int   q1[$];

  adc_scan_avg #(
    .IN_W(IN_W), .LOG2_N(2), .PERIOD(40), .TIMEOUT(30)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .adc_value(adc_value), .adc_done(adc_done),
    .adc_enable(adc_enable), .adc_channel(adc_channel),
    .ch0_avg(ch0_avg), .ch1_avg(ch1_avg),
    .avg_valid(avg_valid), .avg_channel(avg_channel),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reader model
  initial begin : reader
    int   age;
    logic en_prev;
    logic mch;
    adc_done  = 1'b0;
    adc_value = '0;
    age       = 0;
    en_prev   = 1'b0;
    mch       = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (adc_enable && !en_prev) begin
        age = 0;
        mch = adc_channel;
      end else if (adc_enable) begin
        age++;
      end
      if (adc_enable && age == 20 && !withhold && !adc_done) begin
        adc_done = 1'b1;
        if (!mch) adc_value = IN_W'((q0.size() > 0) ? q0.pop_front() : def0);
        else      adc_value = IN_W'((q1.size() > 0) ? q1.pop_front() : def1);
      end
      if (!adc_enable && adc_done && !stuck) adc_done = 1'b0;
      en_prev = adc_enable;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input string tag, input logic lvl, output int t);
    int n = 0;
    while (adc_enable !== lvl && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(adc_enable), 32'(lvl));
    t = cyc;
  endtask

  task automatic conv(input string tag, output int tr, output int tf);
    wait_en({tag, "_rise"}, 1'b1, tr);
    wait_en({tag, "_fall"}, 1'b0, tf);
  endtask

  initial begin : stim
    int t0, tr, tf;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 32'(adc_enable), 0);
    chk("rst_ch", 32'(adc_channel), 0);
    chk("rst_ch0", 32'(ch0_avg), 0);
    chk("rst_ch1", 32'(ch1_avg), 0);
    chk("rst_valid", 32'(avg_valid), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    q0 = {10, 20, 30, 41};
    @(negedge clk);
    rst = 1'b0;

    // Run start timing
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    chk("start_en", 32'(adc_enable), 1);
    chk("start_ch", 32'(adc_channel), 0);
    wait_en("c1_fall", 1'b0, tf);
    chk("c1_fall_time", 32'(tf - t0), 21);
    wait_en("c2_rise", 1'b1, tr);
    chk("c2_rise_time", 32'(tr - t0), 40);
    chk("c2_ch", 32'(adc_channel), 1);
    wait_en("c2_fall", 1'b0, tf);

    // Channel-0 average
    for (int i = 0; i < 4; i++) conv("c3to6", tr, tf);
    wait_en("c7_rise", 1'b1, tr);
    chk("c7_ch", 32'(adc_channel), 0);
    wait_en("c7_fall", 1'b0, tf);
    chk("c7_valid", 32'(avg_valid), 1);
    chk("c7_vch", 32'(avg_channel), 0);
    chk("c7_ch0avg", 32'(ch0_avg), 25);
    chk("c7_ch1avg", 32'(ch1_avg), 0);
    @(posedge clk);
    #1;
    chk("c7_pulse1", 32'(avg_valid), 0);
    conv("c8", tr, tf);
    chk("c8_valid", 32'(avg_valid), 1);
    chk("c8_vch", 32'(avg_channel), 1);
    chk("c8_ch1avg", 32'(ch1_avg), 5);
    chk("c8_ch0avg", 32'(ch0_avg), 25);

    // Full-scale channel 1
    def0 = 100;
    q1 = {8191, 8191, 8191, 8191};
    for (int i = 0; i < 7; i++) conv("fs", tr, tf);
    chk("fs_ch0avg", 32'(ch0_avg), 100);
    chk("fs_ch1_pre", 32'(ch1_avg), 5);
    conv("fs_last", tr, tf);
    chk("fs_valid", 32'(avg_valid), 1);
    chk("fs_vch", 32'(avg_channel), 1);
    chk("fs_ch1avg", 32'(ch1_avg), 8191);

    // Timeout on a ch0 attempt
    withhold = 1'b1;
    def1 = 7;
    q0 = {4, 8, 12, 16};
    wait_en("to_rise", 1'b1, tr);
    chk("to_ch", 32'(adc_channel), 0);
    wait_en("to_fall", 1'b0, tf);
    withhold = 1'b0;
    chk("to_time", 32'(tf - tr), 30);
    chk("to_terr", 32'(timeout_err), 1);
    chk("to_valid", 32'(avg_valid), 0);
    wait_en("to_next", 1'b1, tr);
    chk("to_next_ch", 32'(adc_channel), 1);
    wait_en("to_next_f", 1'b0, tf);
    for (int i = 0; i < 6; i++) conv("to_seq", tr, tf);
    chk("to_ch0_hold", 32'(ch0_avg), 100);
    chk("to_ch1avg", 32'(ch1_avg), 7);
    chk("to_sticky", 32'(timeout_err), 1);
    conv("to_last", tr, tf);
    chk("to_last_valid", 32'(avg_valid), 1);
    chk("to_last_vch", 32'(avg_channel), 0);
    chk("to_ch0avg", 32'(ch0_avg), 10);

    // Stop mid-accumulation
    q0 = {50, 60};
    for (int i = 0; i < 4; i++) conv("st_pre", tr, tf);
    @(negedge clk);
    run = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("st_idle_en", 32'(adc_enable), 0);
    chk("st_ch0_hold", 32'(ch0_avg), 10);
    chk("st_ch1_hold", 32'(ch1_avg), 7);
    chk("st_terr_hold", 32'(timeout_err), 1);
    q0 = {1, 2, 3, 6};
    def1 = 9;
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_en", 32'(adc_enable), 1);
    chk("rs_ch", 32'(adc_channel), 0);
    chk("rs_terr", 32'(timeout_err), 0);
    wait_en("rs_fall", 1'b0, tf);
    for (int i = 0; i < 5; i++) conv("rs_seq", tr, tf);
    chk("rs_ch0_hold", 32'(ch0_avg), 10);
    chk("rs_ch1_hold", 32'(ch1_avg), 7);
    conv("rs_last", tr, tf);
    chk("rs_valid", 32'(avg_valid), 1);
    chk("rs_ch0avg", 32'(ch0_avg), 3);

    // Stuck done extends GAP
    stuck = 1'b1;
    conv("sk", tr, tf);
    chk("sk_fall_time", 32'(tf - tr), 21);
    chk("sk_ch1avg", 32'(ch1_avg), 9);
    while (cyc < tr + 50) begin
      @(posedge clk);
      #1;
    end
    chk("sk_hold_en", 32'(adc_enable), 0);
    chk("sk_hold_done", 32'(adc_done), 1);
    @(negedge clk);
    stuck = 1'b0;
    @(posedge clk);
    #1;
    chk("sk_gap_en", 32'(adc_enable), 0);
    @(posedge clk);
    #1;
    chk("sk_rise_en", 32'(adc_enable), 1);
    chk("sk_rise_ch", 32'(adc_channel), 0);

    // Asynchronous reset mid-CONVERT
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar_en", 32'(adc_enable), 0);
    chk("ar_ch0", 32'(ch0_avg), 0);
    chk("ar_ch1", 32'(ch1_avg), 0);
    chk("ar_vch", 32'(avg_channel), 0);
    chk("ar_terr", 32'(timeout_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
